ahb_slave_mux: RTL
==================

Name: ahb_slave_mux

Overview:
- AHB-Lite data-phase response multiplexer and default slave.
- Sits directly downstream of the address decoder. Consumes its 2-bit mux select and no-map select during the address phase, holds them into the data phase, and steers the selected slave's HRDATA/HREADYOUT/HRESP back to the master.
- Contains the default slave: a two-cycle ERROR response for any active transfer to unmapped space, plus a saturating error counter for debug.

Parameters:
- W, 32, data bus width for HRDATA paths.
- CW, 8, width of the unmapped-access error counter.

Ports:
- HCLK  input  1  bus clock; all state updates on rising edge.
- HRESET  input  1  asynchronous, active-high reset.
- HTRANS  input  2  master transfer type; bit 1 set means NONSEQ or SEQ (active).
- mux_sel_in  input  2  decoder select: 00 memory, 01 GPIO, 10 accelerator, 11 no map.
- hsel_nomap  input  1  decoder no-map select.
- HRDATA_S0, HRDATA_S1, HRDATA_S2  input  W  slave read data.
- HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2  input  1  slave ready.
- HRESP_S0, HRESP_S1, HRESP_S2  input  1  slave response (0 OKAY, 1 ERROR).
- HRDATA  output  W  muxed read data to master.
- HREADY  output  1  muxed ready to master; also fed back to all slaves as HREADY.
- HRESP  output  1  muxed response to master.
- err_count  output  CW  saturating count of ERROR responses issued by the default slave.

Behaviour:
- Global ready is this block's own HREADY output; it is used internally without any external loop.
- sel_q (2b): data-phase select register. Loads mux_sel_in on a rising HCLK edge when HREADY=1; holds otherwise. Reset value 2'b11 (default slave).
- Output mux, selected by sel_q:
  - 00: S0 HRDATA/HREADYOUT/HRESP.
  - 01: S1 HRDATA/HREADYOUT/HRESP.
  - 10: S2 HRDATA/HREADYOUT/HRESP.
  - 11: default slave; HRDATA = 0, HREADY = def_ready, HRESP = def_resp.
  - The mux is purely combinational from sel_q and slave inputs; no added latency beyond the AHB address/data pipeline.
- Default slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: def_ready=1, def_resp=0. If HREADY=1 and hsel_nomap=1 and HTRANS[1]=1 at the edge, go to ERR1. Otherwise stay.
  - ERR1: def_ready=0, def_resp=1. Unconditionally go to ERR2 next cycle.
  - ERR2: def_ready=1, def_resp=1.
    - If hsel_nomap=1 and HTRANS[1]=1 at this edge (HREADY is 1 here), go to ERR1 for back-to-back errors.
    - Otherwise go to IDLE.
  - IDLE or BUSY transfers (HTRANS[1]=0) to no-map space get a zero-wait OKAY: FSM stays IDLE.
- err_count increments by 1 on each ERR1 entry. It saturates at all-ones (no wrap) and resets to 0.
- Reset values: sel_q=11, FSM=IDLE, err_count=0. Resulting outputs: HRDATA=0, HREADY=1, HRESP=0, err_count=0.
- Reset asserted mid-transfer (any state, including ERR1) returns immediately (asynchronously) to the reset values above. The pending transfer is abandoned.
- Slave wait states: while the selected slave drives HREADYOUT=0, sel_q holds. A new mux_sel_in presented during the stall is not captured until the cycle HREADY=1.
- An ERROR response from a real slave passes through unchanged and does not affect err_count.
- An unmapped mux_sel_in value with hsel_nomap=0 does not occur. If it does, sel_q still loads 11 and the default slave stays IDLE (OKAY).

Test Plan:
- Reset, then idle bus: HRESET pulse with HTRANS=00 → HRDATA=0, HREADY=1, HRESP=0, err_count=0.
- Memory read: NONSEQ with mux_sel_in=00; next cycle HRDATA_S0=32'hDEAD_BEEF, HREADYOUT_S0=1 → HRDATA=32'hDEAD_BEEF, HREADY=1, HRESP=0 in the data phase.
- GPIO wait states: mux_sel_in=01 captured; HREADYOUT_S1=0 for 3 cycles while mux_sel_in changes to 10 → HREADY=0 for 3 cycles and sel_q stays 01. Accelerator data appears only after the stall clears.
- Unmapped access: NONSEQ to 0x6000_0000 (mux_sel_in=11, hsel_nomap=1) → cycle 1 HREADY=0/HRESP=1, cycle 2 HREADY=1/HRESP=1, err_count=1.
- Back-to-back unmapped NONSEQs, the second issued in ERR2 → two full ERR1/ERR2 pairs with no IDLE gap, err_count=2. A BUSY transfer to unmapped space → OKAY, zero wait, count unchanged.
- Saturation and mid-error reset: force 300 unmapped accesses with CW=8 → err_count stays 8'hFF. Assert HRESET during ERR1 → HREADY=1, HRESP=0, err_count=0 immediately.

Source files
------------

// File: rtl/ahb_slave_mux_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_mux_if
//   Bundle of the AHB-Lite signals seen by the data-phase response mux.
//
//   Master-side request (driven by master/decoder):
//     HTRANS      transfer type (bit 1 set = NONSEQ/SEQ)
//     mux_sel_in  decoder select: 00 mem, 01 GPIO, 10 accel, 11 no map
//     hsel_nomap  decoder no-map select
//   Slave responses (driven by the three real slaves):
//     HRDATA_Sx, HREADYOUT_Sx, HRESP_Sx  for x = 0..2
//   Muxed response (driven by the mux):
//     HRDATA, HREADY, HRESP  back to master (HREADY also to all slaves)
//     err_count              saturating count of default-slave ERRORs
//
//   Modports:
//     slave  - view taken by ahb_slave_mux
//     master - view taken by the environment (master, decoder and slaves)
// ---------------------------------------------------------------------------
interface ahb_slave_mux_if #(
    parameter int W  = 32,
    parameter int CW = 8
);
    logic [1:0]    HTRANS;
    logic [1:0]    mux_sel_in;
    logic          hsel_nomap;

    logic [W-1:0]  HRDATA_S0;
    logic [W-1:0]  HRDATA_S1;
    logic [W-1:0]  HRDATA_S2;
    logic          HREADYOUT_S0;
    logic          HREADYOUT_S1;
    logic          HREADYOUT_S2;
    logic          HRESP_S0;
    logic          HRESP_S1;
    logic          HRESP_S2;

    logic [W-1:0]  HRDATA;
    logic          HREADY;
    logic          HRESP;
    logic [CW-1:0] err_count;

    modport slave (
        input  HTRANS,
        input  mux_sel_in,
        input  hsel_nomap,
        input  HRDATA_S0,
        input  HRDATA_S1,
        input  HRDATA_S2,
        input  HREADYOUT_S0,
        input  HREADYOUT_S1,
        input  HREADYOUT_S2,
        input  HRESP_S0,
        input  HRESP_S1,
        input  HRESP_S2,
        output HRDATA,
        output HREADY,
        output HRESP,
        output err_count
    );

    modport master (
        output HTRANS,
        output mux_sel_in,
        output hsel_nomap,
        output HRDATA_S0,
        output HRDATA_S1,
        output HRDATA_S2,
        output HREADYOUT_S0,
        output HREADYOUT_S1,
        output HREADYOUT_S2,
        output HRESP_S0,
        output HRESP_S1,
        output HRESP_S2,
        input  HRDATA,
        input  HREADY,
        input  HRESP,
        input  err_count
    );
endinterface

// File: rtl/ahb_slave_mux.sv
// ---------------------------------------------------------------------------
// ahb_slave_mux
//   AHB-Lite data-phase response multiplexer with built-in default slave.
//
//   The decoder's select is captured in the address phase (whenever HREADY
//   is high) and held through the data phase to steer the selected slave's
//   HRDATA/HREADYOUT/HRESP back to the master. Select 11 routes to the
//   default slave, which answers active transfers to unmapped space with a
//   two-cycle ERROR and counts them in a saturating debug counter.
//
//   Ports:
//     HCLK    bus clock, rising-edge
//     HRESET  asynchronous active-high reset
//     bus     ahb_slave_mux_if.slave (request in, slave responses in,
//             muxed HRDATA/HREADY/HRESP and err_count out)
// ---------------------------------------------------------------------------
module ahb_slave_mux #(
    parameter int W  = 32,
    parameter int CW = 8
) (
    input  logic          HCLK,
    input  logic          HRESET,
    ahb_slave_mux_if.slave bus
);

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        SEL_MEM   = 2'b00,
        SEL_GPIO  = 2'b01,
        SEL_ACCEL = 2'b10,
        SEL_NOMAP = 2'b11
    } sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ERR1 = 2'b01,
        ERR2 = 2'b10
    } def_state_t;

    sel_t          sel_q;
    def_state_t    state_q;
    def_state_t    state_d;
    logic [CW-1:0] err_cnt_q;

    logic          def_ready;
    logic          def_resp;
    logic          xfer_active;
    logic          nomap_req;

    logic [W-1:0]  hrdata_mux;
    logic          hready_mux;
    logic          hresp_mux;

    htrans_t       htrans;
    assign htrans = htrans_t'(bus.HTRANS);

    assign xfer_active = (htrans == TR_NONSEQ) || (htrans == TR_SEQ);
    assign nomap_req   = bus.hsel_nomap && xfer_active;

    // -----------------------------------------------------------------------
    // Data-phase select register
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_q <= SEL_NOMAP;
        end else if (hready_mux) begin
            sel_q <= sel_t'(bus.mux_sel_in);
        end
    end

    // -----------------------------------------------------------------------
    // Default slave FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        def_ready = 1'b1;
        def_resp  = 1'b0;
        unique case (state_q)
            IDLE: begin
                def_ready = 1'b1;
                def_resp  = 1'b0;
                // HREADY can be low here while a real slave is stalling;
                // the no-map request is then not yet in its address phase.
                if (hready_mux && nomap_req) begin
                    state_d = ERR1;
                end
            end
            ERR1: begin
                def_ready = 1'b0;
                def_resp  = 1'b1;
                state_d   = ERR2;
            end
            ERR2: begin
                def_ready = 1'b1;
                def_resp  = 1'b1;
                // HREADY is necessarily high in ERR2, so only the request
                // itself decides between back-to-back error and idle.
                state_d   = nomap_req ? ERR1 : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Saturating unmapped-access counter, bumped on every ERR1 entry
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            err_cnt_q <= '0;
        end else if ((state_d == ERR1) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + CW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Response mux
    // -----------------------------------------------------------------------
    always_comb begin
        hrdata_mux = '0;
        hready_mux = 1'b1;
        hresp_mux  = 1'b0;
        unique case (sel_q)
            SEL_MEM: begin
                hrdata_mux = bus.HRDATA_S0;
                hready_mux = bus.HREADYOUT_S0;
                hresp_mux  = bus.HRESP_S0;
            end
            SEL_GPIO: begin
                hrdata_mux = bus.HRDATA_S1;
                hready_mux = bus.HREADYOUT_S1;
                hresp_mux  = bus.HRESP_S1;
            end
            SEL_ACCEL: begin
                hrdata_mux = bus.HRDATA_S2;
                hready_mux = bus.HREADYOUT_S2;
                hresp_mux  = bus.HRESP_S2;
            end
            SEL_NOMAP: begin
                hrdata_mux = '0;
                hready_mux = def_ready;
                hresp_mux  = def_resp;
            end
            default: begin
                hrdata_mux = '0;
                hready_mux = 1'b1;
                hresp_mux  = 1'b0;
            end
        endcase
    end

    assign bus.HRDATA    = hrdata_mux;
    assign bus.HREADY    = hready_mux;
    assign bus.HRESP     = hresp_mux;
    assign bus.err_count = err_cnt_q;

    // The two-cycle error response never shortens or stretches.
    a_err1_to_err2: assert property (
        @(posedge HCLK) disable iff (HRESET) (state_q == ERR1) |=> (state_q == ERR2)
    );

endmodule
